booth_arb_seq: RTL and testbench
================================

# booth_arb_seq

Iterative radix-2 Booth multiplier with a two-port round-robin front end. It multiplies two signed WIDTH-bit operands one Booth step per clock and returns a signed 2*WIDTH-bit product over a valid/ready handshake. It lets two requesters share one multiplier datapath instead of instantiating a fully unrolled combinational array per requester.

## Interface
- WIDTH, 6, operand width in bits; two's complement; must be ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_in1  input  WIDTH  requester 0 multiplicand, signed.
- req0_in2  input  WIDTH  requester 0 multiplier, signed.
- req0_ready  output  1  requester 0 operands accepted this cycle.
- req1_valid, req1_in1, req1_in2, req1_ready  same as port 0, for requester 1.
- out  output  2*WIDTH  signed product.
- out_id  output  1  index of the requester that owns `out`.
- out_valid  output  1  `out` and `out_id` are valid.
- out_ready  input  1  consumer takes the result this cycle.

## Operation
- States:
  - IDLE: arbitrate and accept.
  - CALC: one Booth step per cycle, WIDTH cycles.
  - DONE: hold the result until the consumer accepts it.
- Arbitration in IDLE:
  - Grant goes to the single requester with valid high.
  - If both are valid, grant goes to `prio`.
  - `reqN_ready = rst_n & (state==IDLE) & grant==N`. This is combinational from valid; at most one ready is high.
  - An accept is `reqN_valid & reqN_ready`.
- On accept:
  - M ← granted in1.
  - A ← 0 (WIDTH+1 bits).
  - Q ← granted in2.
  - q_m1 ← 0.
  - cnt ← 0.
  - id ← N.
  - prio ← ~N.
  - state → CALC.
- CALC step on each edge:
  - If {Q[0], q_m1} = 01: A ← A + sext(M).
  - If {Q[0], q_m1} = 10: A ← A − sext(M).
  - Otherwise A is unchanged.
  - sext(M) is M sign-extended to WIDTH+1 bits. The add/subtract is modulo 2^(WIDTH+1).
  - Then arithmetically shift {A, Q, q_m1} right by 1; the MSB of A is replicated.
  - cnt ← cnt+1.
  - After the step with cnt==WIDTH−1: out ← {A[WIDTH−1:0], Q} of the post-shift value, out_id ← id, out_valid ← 1, state → DONE.
- Products are exact for all operand pairs, including most-negative × most-negative (the extra A bit prevents overflow).
- DONE:
  - out, out_id and out_valid are held stable while out_ready is low.
  - On `out_valid & out_ready`: out_valid ← 0, state → IDLE.
  - out and out_id keep their last values until the next result is loaded.
- Requests presented outside IDLE are not accepted. The requester must hold valid and its operands until it sees ready.
- Reset (async, any state): state ← IDLE, out_valid ← 0, out ← 0, out_id ← 0, prio ← 0, cnt ← 0, A/Q/M/q_m1 ← 0, id ← 0, both ready ← 0 while rst_n is low. An in-flight operation is discarded with no output.

## Timing
- Accept at edge E0. CALC steps occur on edges E1..E_WIDTH. out_valid is high from edge E_WIDTH.
- Latency is WIDTH cycles from the accept edge to out_valid.
- With out_ready held high, the result handshake is at edge E_WIDTH+1 and the earliest next accept is at edge E_WIDTH+2.
- Maximum throughput is one product per WIDTH+2 cycles.
- If out_ready is high in the same cycle out_valid rises, the handshake completes on the next edge. There is no combinational path from out_ready to any output.
- Simultaneous valids: exactly one requester is granted. The loser keeps valid asserted and is served on the next IDLE visit, because prio has flipped to it.
- Deassertion of rst_n takes effect synchronously to clk. The first accept is possible on the first edge after release.

## Test plan
- Single op, WIDTH=6: req0 sends in1=3, in2=−2 (6'h3E). Required: out=12'hFFA, out_id=0, out_valid exactly 6 cycles after the accept edge.
- Corner values:
  - −32 × −32 → 12'h400.
  - 31 × −32 → 12'hC20.
  - −32 × 31 → 12'hC20.
  - 0 × −1 → 12'h000.
  - Run an exhaustive 4096-pair sweep from req1 against a reference model.
- Contention: both valid from reset with distinct operands. Required grants in order 0, 1, 0, 1. out_id matches each grant and each product is correct.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required: out, out_id and out_valid stable, both readies 0, no new accept. Raise out_ready: handshake occurs, and the next accept is exactly one cycle later.
- Reset mid-operation: assert rst_n low at step 3 of CALC. Required: out_valid=0 and out=0 immediately, without waiting for a clock edge. After release, a fresh op (5 × 7) returns 12'h023 with correct latency and prio=0.
- Single-requester stream: req1 is the only requester, with valid held high and out_ready held high. Required: a back-to-back accept every 8 cycles with correct products.

Source files
------------

// File: rtl/booth_arb_seq.sv
// Iterative radix-2 Booth multiplier shared by two requesters through a round-robin front end.
// One Booth step per clock; result returned over a valid/ready handshake.
module booth_arb_seq #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [WIDTH-1:0]     req0_in1,
    input  logic [WIDTH-1:0]     req0_in2,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [WIDTH-1:0]     req1_in1,
    input  logic [WIDTH-1:0]     req1_in2,
    output logic                 req1_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_id,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic                 qm1_q, qm1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 id_q, id_d;
    logic                 prio_q, prio_d;
    logic [2*WIDTH-1:0]   out_q, out_d;
    logic                 out_id_q, out_id_d;
    logic                 out_valid_q, out_valid_d;

    logic                 grant;
    logic                 idle;
    logic [WIDTH:0]       m_ext;
    logic [WIDTH:0]       a_sum;
    logic [WIDTH:0]       a_sh;
    logic [WIDTH-1:0]     q_sh;

    // Contention goes to prio; otherwise the lone valid requester wins.
    assign grant      = (req0_valid & req1_valid) ? prio_q : req1_valid;
    assign idle       = (state_q == IDLE);
    assign req0_ready = rst_n & idle & req0_valid & ~grant;
    assign req1_ready = rst_n & idle & req1_valid & grant;

    assign out       = out_q;
    assign out_id    = out_id_q;
    assign out_valid = out_valid_q;

    // One Booth step: add/sub on the WIDTH+1 accumulator, then arithmetic shift of {A,Q,q_m1}.
    always_comb begin
        m_ext = {m_q[WIDTH-1], m_q};
        case ({q_q[0], qm1_q})
            2'b01:   a_sum = a_q + m_ext;
            2'b10:   a_sum = a_q - m_ext;
            default: a_sum = a_q;
        endcase
        a_sh = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_sh = {a_sum[0], q_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        qm1_d       = qm1_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        prio_d      = prio_q;
        out_d       = out_q;
        out_id_d    = out_id_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (req0_ready | req1_ready) begin
                    m_d     = grant ? req1_in1 : req0_in1;
                    q_d     = grant ? req1_in2 : req0_in2;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    id_d    = grant;
                    prio_d  = ~grant;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d   = a_sh;
                q_d   = q_sh;
                qm1_d = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    out_d       = {a_sh[WIDTH-1:0], q_sh};
                    out_id_d    = id_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            qm1_q       <= 1'b0;
            cnt_q       <= '0;
            id_q        <= 1'b0;
            prio_q      <= 1'b0;
            out_q       <= '0;
            out_id_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            qm1_q       <= qm1_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            prio_q      <= prio_d;
            out_q       <= out_d;
            out_id_q    <= out_id_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_booth_arb_seq.sv
// Bench for booth_arb_seq: corner-value table, contention, backpressure, reset and a full req1 sweep,
// with a scoreboard filled on each accept and drained on each result handshake.
module tb_booth_arb_seq;
    localparam int W = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req0_valid, req1_valid;
    logic [W-1:0]    req0_in1, req0_in2, req1_in1, req1_in2;
    logic            req0_ready, req1_ready;
    logic [2*W-1:0]  out;
    logic            out_id, out_valid, out_ready;

    always #5 clk = ~clk;

    booth_arb_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_ready(req1_ready),
        .out(out), .out_id(out_id), .out_valid(out_valid), .out_ready(out_ready)
    );

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          last_acc_port = -1;
    int          last_acc_cyc = 0;
    logic [2*W:0] sb[$];

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Samples at the falling edge (inputs settled), then returns 1ns after the next rising edge.
    task automatic tick();
        logic [2*W:0] e;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (req0_valid && req1_valid)
                check("one_ready", {31'b0, req0_ready & req1_ready}, 32'd0);
            if (req0_valid && req0_ready) begin
                sb.push_back({1'b0, model(req0_in1, req0_in2)});
                acc_cnt++; last_acc_port = 0; last_acc_cyc = cyc;
                $display("accept port=0 %0h x %0h at cycle %0d", req0_in1, req0_in2, cyc);
            end else if (req1_valid && req1_ready) begin
                sb.push_back({1'b1, model(req1_in1, req1_in2)});
                acc_cnt++; last_acc_port = 1; last_acc_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    fail_now("sb_underflow");
                end else begin
                    e = sb.pop_front();
                    check("sb_out", {20'b0, out}, {20'b0, e[2*W-1:0]});
                    check("sb_id", {31'b0, out_id}, {31'b0, e[2*W]});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(output int port);
        int start;
        int n;
        start = acc_cnt;
        n = 0;
        while (acc_cnt == start && n < 20) begin
            tick();
            n++;
        end
        if (acc_cnt == start) fail_now("accept_timeout");
        port = last_acc_port;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        if (!out_valid) fail_now("out_valid_timeout");
    endtask

    initial begin
        vec_t          vt[5];
        int            p, lat, n0, n1, acc0, prev;
        logic [2*W-1:0] held_out;
        logic          held_id;

        vt[0] = '{6'h03, 6'h3E, 12'hFFA};
        vt[1] = '{6'h20, 6'h20, 12'h400};
        vt[2] = '{6'h1F, 6'h20, 12'hC20};
        vt[3] = '{6'h20, 6'h1F, 12'hC20};
        vt[4] = '{6'h00, 6'h3F, 12'h000};

        rst_n = 1'b0; out_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_in1 = '0; req0_in2 = '0; req1_in1 = '0; req1_in2 = '0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rst_ready0", {31'b0, req0_ready}, 32'd0);
        check("rst_ready1", {31'b0, req1_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out", {20'b0, out}, 32'd0);
        check("rst_out_id", {31'b0, out_id}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // Corner-value table from requester 0
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req0_in1 = vt[i].a; req0_in2 = vt[i].b; req0_valid = 1'b1;
            wait_accept(p);
            req0_valid = 1'b0;
            check("tbl_port", p, 0);
            wait_valid(lat);
            check("tbl_latency", lat, 6);
            check("tbl_out", {20'b0, out}, {20'b0, vt[i].exp});
            check("tbl_id", {31'b0, out_id}, 32'd0);
            $display("vec %0d: %0h x %0h -> %0h latency %0d", i, vt[i].a, vt[i].b, out, lat);
            tick();
        end

        // Contention from reset: grants must alternate 0,1,0,1
        rst_n = 1'b0;
        req0_in1 = 6'h05; req0_in2 = 6'h3D; req0_valid = 1'b1;
        req1_in1 = 6'h0B; req1_in2 = 6'h04; req1_valid = 1'b1;
        tick();
        rst_n = 1'b1;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 4; k++) begin
            wait_accept(p);
            check("grant_order", p, k % 2);
            if (p == 0) begin
                n0++;
                if (n0 < 2) begin req0_in1 = 6'h39; req0_in2 = 6'h02; end
                else req0_valid = 1'b0;
            end else begin
                n1++;
                if (n1 < 2) begin req1_in1 = 6'h20; req1_in2 = 6'h20; end
                else req1_valid = 1'b0;
            end
        end
        wait_valid(lat);
        tick();

        // Backpressure: result held 10 cycles, nothing accepted meanwhile
        out_ready = 1'b0;
        req0_in1 = 6'h09; req0_in2 = 6'h3C; req0_valid = 1'b1;
        wait_accept(p);
        req0_valid = 1'b0;
        wait_valid(lat);
        check("bp_out", {20'b0, out}, 32'hFDC);
        held_out = out; held_id = out_id;
        req0_in1 = 6'h01; req0_in2 = 6'h01; req0_valid = 1'b1;
        req1_in1 = 6'h02; req1_in2 = 6'h03; req1_valid = 1'b1;
        acc0 = acc_cnt;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_hold_out", {20'b0, out}, {20'b0, held_out});
            check("bp_hold_id", {31'b0, out_id}, {31'b0, held_id});
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_readies", {30'b0, req1_ready, req0_ready}, 32'd0);
        end
        check("bp_no_accept", acc_cnt, acc0);
        out_ready = 1'b1;
        tick();
        check("bp_released", {31'b0, out_valid}, 32'd0);
        acc0 = acc_cnt;
        tick();
        check("bp_next_accept", acc_cnt, acc0 + 1);
        check("bp_next_port", last_acc_port, 1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_valid(lat);
        tick();

        // Reset during CALC step 3
        req0_in1 = 6'h3B; req0_in2 = 6'h09; req0_valid = 1'b1;
        wait_accept(p);
        req0_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_out", {20'b0, out}, 32'd0);
        req0_in1 = 6'h05; req0_in2 = 6'h07; req0_valid = 1'b1;
        req1_in1 = 6'h03; req1_in2 = 6'h03; req1_valid = 1'b1;
        tick();
        rst_n = 1'b1;
        wait_accept(p);
        check("post_rst_prio", p, 0);
        req0_valid = 1'b0;
        wait_valid(lat);
        check("post_rst_latency", lat, 6);
        check("post_rst_out", {20'b0, out}, 32'h023);
        tick();
        wait_accept(p);
        check("post_rst_second", p, 1);
        req1_valid = 1'b0;
        wait_valid(lat);
        tick();

        // Back-to-back stream from requester 1 covering every operand pair
        req1_valid = 1'b1;
        prev = 0;
        for (int i = 0; i < 4096; i++) begin
            logic [11:0] iv;
            iv = 12'(i);
            req1_in1 = iv[11:6]; req1_in2 = iv[5:0];
            wait_accept(p);
            if (i > 0) check("stream_spacing", last_acc_cyc - prev, 8);
            prev = last_acc_cyc;
        end
        req1_valid = 1'b0;
        wait_valid(lat);
        tick();
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
